// File: rtl/sii_ncu_xfer_chk.sv
// Passive checker and capture block for inbound SII->NCU transfers.
// Follows the req/gnt handshake, captures the header and PB payload beats,
// checks per-lane payload parity, flags protocol violations and grant
// timeouts, and keeps saturating packet and error counters.
module sii_ncu_xfer_chk #(
   parameter int DW      = 32,
   parameter int PB      = 4,
   parameter int ODD_PAR = 0,
   parameter int TMO     = 256,
   parameter int CNT_W   = 16
) (
   input  logic                iol2clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                sii_ncu_req,
   input  logic                ncu_sii_gnt,
   input  logic [DW-1:0]       sii_ncu_data,
   input  logic [DW/16-1:0]    sii_ncu_dparity,
   input  logic                err_clr,
   output logic                pkt_vld,
   output logic [DW-1:0]       pkt_hdr,
   output logic [PB*DW-1:0]    pkt_pld,
   output logic                pkt_par_err,
   output logic                err_spur_gnt,
   output logic                err_gnt_ovl,
   output logic                err_req_drop,
   output logic                err_tmo,
   output logic [CNT_W-1:0]    pkt_cnt,
   output logic [CNT_W-1:0]    err_cnt,
   output logic                busy
);

   localparam int   NL      = DW / 16;
   localparam int   BW      = (PB > 1) ? $clog2(PB) : 1;
   localparam int   TW      = $clog2(TMO + 1);
   localparam logic PAR_REF = (ODD_PAR != 0);

   typedef enum logic [1:0] {IDLE, WAIT_GNT, HDR, PLD} state_t;

   state_t            state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [DW-1:0]     hdr_w;
   logic [PB*DW-1:0]  pld_w;
   logic [PB*DW-1:0]  pld_done;
   logic              par_acc;
   logic [NL-1:0]     lane_err;
   logic              beat_err;
   logic              par_final;
   logic              hdr_cap, pld_cap, done;
   logic              ev_spur, ev_drop, ev_tmo, ev_ovl;
   logic [2:0]        ev_sum;

   // Adds a small increment and clamps at the all-ones value.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [2:0]       b);
      logic [CNT_W+2:0] s;
      s = {3'b000, a} + {{CNT_W{1'b0}}, b};
      return (|s[CNT_W+2:CNT_W]) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // Per-lane parity check of the current data beat against the chosen sense.
   always_comb begin
      for (int i = 0; i < NL; i++)
         lane_err[i] = (^sii_ncu_data[16*i +: 16]) ^ sii_ncu_dparity[i] ^ PAR_REF;
   end

   assign beat_err  = |lane_err;
   assign par_final = par_acc | beat_err;

   // Final payload image: stored beats plus the last beat seen this cycle.
   always_comb begin
      pld_done = pld_w;
      pld_done[(PB-1)*DW +: DW] = sii_ncu_data;
   end

   // Next-state, beat/timer update and error-event decode.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
      state_d = state_q;
      beat_d  = beat_q;
      timer_d = timer_q;
      hdr_cap = 1'b0;
      pld_cap = 1'b0;
      done    = 1'b0;
      ev_spur = 1'b0;
      ev_drop = 1'b0;
      ev_tmo  = 1'b0;
      ev_ovl  = 1'b0;
      unique case (state_q)
         IDLE: begin
            beat_d  = '0;
            timer_d = '0;
            if (enable && sii_ncu_req) begin
               if (ncu_sii_gnt) begin
                  state_d = HDR;
               end else begin
                  state_d = WAIT_GNT;
                  timer_d = TW'(1);
               end
            end else if (enable && ncu_sii_gnt) begin
               ev_spur = 1'b1;
            end
         end
         WAIT_GNT: begin
            if (ncu_sii_gnt) begin
               state_d = HDR;
               timer_d = '0;
            end else if (!enable) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (!sii_ncu_req) begin
               ev_drop = 1'b1;
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q < TW'(TMO)) begin
               // Timer stops at TMO, so the timeout event fires once per request.
               timer_d = timer_q + TW'(1);
               ev_tmo  = (timer_q == TW'(TMO - 1));
            end
         end
         HDR: begin
            hdr_cap = 1'b1;
            ev_ovl  = ncu_sii_gnt;
            beat_d  = '0;
            state_d = PLD;
         end
         PLD: begin
            pld_cap = 1'b1;
            ev_ovl  = ncu_sii_gnt;
            if (beat_q == BW'(PB - 1)) begin
               done   = 1'b1;
               beat_d = '0;
               if (enable && sii_ncu_req) begin
                  state_d = WAIT_GNT;
                  timer_d = TW'(1);
               end else begin
                  state_d = IDLE;
                  timer_d = '0;
               end
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ev_sum = 3'(ev_spur) + 3'(ev_drop) + 3'(ev_tmo) + 3'(ev_ovl)
                 + 3'(done & par_final);

   // Control state: FSM, beat counter, grant timer.
   always_ff @(posedge iol2clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         timer_q <= timer_d;
      end
   end

   // Working capture registers for the transfer in flight.
   always_ff @(posedge iol2clk) begin
      // NOTE: capture storage is reset too, because reset must drive every visible output to zero.
      if (reset) begin
         hdr_w   <= '0;
         pld_w   <= '0;
         par_acc <= 1'b0;
      end else begin
         if (hdr_cap) begin
            hdr_w   <= sii_ncu_data;
            par_acc <= 1'b0;
         end
         if (pld_cap) begin
            par_acc <= par_final;
            for (int k = 0; k < PB; k++)
               if (beat_q == BW'(k))
                  pld_w[k*DW +: DW] <= sii_ncu_data;
         end
      end
   end

   // Packet outputs, held from one completed capture to the next.
   always_ff @(posedge iol2clk) begin
      if (reset) begin
         pkt_vld     <= 1'b0;
         pkt_hdr     <= '0;
         pkt_pld     <= '0;
         pkt_par_err <= 1'b0;
         pkt_cnt     <= '0;
      end else begin
         pkt_vld <= done;
         if (done) begin
            pkt_hdr     <= hdr_w;
            pkt_pld     <= pld_done;
            pkt_par_err <= par_final;
            pkt_cnt     <= sat_add(pkt_cnt, 3'd1);
         end
      end
   end

   // Sticky error flags and error counter; a same-cycle event beats err_clr.
   always_ff @(posedge iol2clk) begin
      if (reset) begin
         err_spur_gnt <= 1'b0;
         err_gnt_ovl  <= 1'b0;
         err_req_drop <= 1'b0;
         err_tmo      <= 1'b0;
         err_cnt      <= '0;
      end else begin
         err_spur_gnt <= (err_spur_gnt & ~err_clr) | ev_spur;
         err_gnt_ovl  <= (err_gnt_ovl  & ~err_clr) | ev_ovl;
         err_req_drop <= (err_req_drop & ~err_clr) | ev_drop;
         err_tmo      <= (err_tmo      & ~err_clr) | ev_tmo;
         err_cnt      <= sat_add(err_clr ? '0 : err_cnt, ev_sum);
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sii_ncu_xfer_chk.sv
// Scoreboard bench for sii_ncu_xfer_chk: two instances (32-bit/4-beat/even
// parity with short timeout and 2-bit counters, and 64-bit/2-beat/odd parity)
// share one bus and are selected by their enable inputs.
module tb_sii_ncu_xfer_chk;

   typedef struct {
      logic [63:0]  hdr;
      logic [127:0] pld;
      logic         perr;
      logic [15:0]  pcnt;
      logic [15:0]  ecnt;
      int           cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en_a = 1'b0, en_b = 1'b0;
   logic        req = 1'b0, gnt = 1'b0, err_clr = 1'b0;
   logic [63:0] data = '0;
   logic [3:0]  par = '0;

   logic         vld_a, perr_a, spur_a, ovl_a, drop_a, tmo_a, busy_a;
   logic [31:0]  hdr_a;
   logic [127:0] pld_a;
   logic [1:0]   pcnt_a, ecnt_a;
   logic         vld_b, perr_b, spur_b, ovl_b, drop_b, tmo_b, busy_b;
   logic [63:0]  hdr_b;
   logic [127:0] pld_b;
   logic [15:0]  pcnt_b, ecnt_b;

   int   n_vec = 0, n_bad = 0, cyc = 0;
   int   exp_pkt[2], exp_err[2];
   exp_t q_a[$], q_b[$];
   exp_t e_a, e_b;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sii_ncu_xfer_chk #(.DW(32), .PB(4), .ODD_PAR(0), .TMO(8), .CNT_W(2)) dut_a (
      .iol2clk(clk), .reset(reset), .enable(en_a), .sii_ncu_req(req),
      .ncu_sii_gnt(gnt), .sii_ncu_data(data[31:0]), .sii_ncu_dparity(par[1:0]),
      .err_clr(err_clr), .pkt_vld(vld_a), .pkt_hdr(hdr_a), .pkt_pld(pld_a),
      .pkt_par_err(perr_a), .err_spur_gnt(spur_a), .err_gnt_ovl(ovl_a),
      .err_req_drop(drop_a), .err_tmo(tmo_a), .pkt_cnt(pcnt_a), .err_cnt(ecnt_a),
      .busy(busy_a));

   sii_ncu_xfer_chk #(.DW(64), .PB(2), .ODD_PAR(1), .TMO(256), .CNT_W(16)) dut_b (
      .iol2clk(clk), .reset(reset), .enable(en_b), .sii_ncu_req(req),
      .ncu_sii_gnt(gnt), .sii_ncu_data(data), .sii_ncu_dparity(par),
      .err_clr(err_clr), .pkt_vld(vld_b), .pkt_hdr(hdr_b), .pkt_pld(pld_b),
      .pkt_par_err(perr_b), .err_spur_gnt(spur_b), .err_gnt_ovl(ovl_b),
      .err_req_drop(drop_b), .err_tmo(tmo_b), .pkt_cnt(pcnt_b), .err_cnt(ecnt_b),
      .busy(busy_b));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Correct parity bits for all four 16-bit lanes of the shared bus.
   function automatic logic [3:0] par_of(input logic [63:0] d, input logic odd);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = (^d[16*i +: 16]) ^ odd;
      return p;
   endfunction

   function automatic int sat(input int v, input int sel);
      int mx = (sel == 0) ? 3 : 65535;
      return (v > mx) ? mx : v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sample flags, counters and busy of one instance in the current cycle.
   task automatic chk(input int sel, input string tag, input logic [3:0] flags,
                      input int ecnt, input int pcnt, input logic bsy);
      @(negedge clk);
      if (sel == 0) begin
         check({tag, "_a_flags"}, {spur_a, ovl_a, drop_a, tmo_a}, flags);
         check({tag, "_a_errcnt"}, ecnt_a, ecnt);
         check({tag, "_a_pktcnt"}, pcnt_a, pcnt);
         check({tag, "_a_busy"}, busy_a, bsy);
      end else begin
         check({tag, "_b_flags"}, {spur_b, ovl_b, drop_b, tmo_b}, flags);
         check({tag, "_b_errcnt"}, ecnt_b, ecnt);
         check({tag, "_b_pktcnt"}, pcnt_b, pcnt);
         check({tag, "_b_busy"}, busy_b, bsy);
      end
   endtask

   task automatic chk_zero(input string tag);
      @(negedge clk);
      check({tag, "_a_ctl"}, {vld_a, perr_a, spur_a, ovl_a, drop_a, tmo_a, busy_a, pcnt_a, ecnt_a}, 0);
      check({tag, "_a_hdr"}, hdr_a, 0);
      check({tag, "_a_pld"}, pld_a, 0);
      check({tag, "_b_ctl"}, {vld_b, perr_b, spur_b, ovl_b, drop_b, tmo_b, busy_b, pcnt_b, ecnt_b}, 0);
      check({tag, "_b_pld"}, {hdr_b, pld_b}, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1; req = 1'b0; gnt = 1'b0; err_clr = 1'b0;
      step(); step();
      reset = 1'b0;
      exp_pkt = '{0, 0};
      exp_err = '{0, 0};
      chk_zero("reset");
   endtask

   // One transfer: d wait cycles then gnt, header, payload beats.
   // flip is XORed into the correct parity (4 bits per beat), ev counts the
   // non-parity error events the transfer causes, rst_beat aborts with reset,
   // den_beat drops en_a on that beat.
   task automatic xfer(input int sel, input logic [63:0] h,
                       input logic [63:0] p0, input logic [63:0] p1,
                       input logic [63:0] p2, input logic [63:0] p3,
                       input int d, input bit keep_req, input logic [15:0] flip,
                       input int ovl_beat, input int ev, input int rst_beat,
                       input int den_beat, input bit tmo_chk);
      logic [63:0] pl[4];
      exp_t        e;
      int          pb;
      logic        odd;
      pl  = '{p0, p1, p2, p3};
      pb  = (sel == 0) ? 4 : 2;
      odd = (sel == 1);
      for (int i = 0; i <= d; i++) begin
         req  = 1'b1;
         gnt  = (i == d);
         data = 64'hBAD0_0000_0000_0000 | 64'(i);
         par  = 4'hF;
         if (i == d && rst_beat < 0) begin
            e.hdr  = (sel == 0) ? {32'h0, h[31:0]} : h;
            e.pld  = (sel == 0) ? {pl[3][31:0], pl[2][31:0], pl[1][31:0], pl[0][31:0]}
                                : {pl[1], pl[0]};
            e.perr = |flip;
            exp_pkt[sel] = sat(exp_pkt[sel] + 1, sel);
            exp_err[sel] = sat(exp_err[sel] + ev + int'(|flip), sel);
            e.pcnt = 16'(exp_pkt[sel]);
            e.ecnt = 16'(exp_err[sel]);
            e.cyc  = cyc + pb + 2;
            if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
         end
         if (tmo_chk && (i == 7 || i == 8)) begin
            @(negedge clk);
            check((i == 7) ? "tmo_before" : "tmo_at_limit", tmo_a, (i == 8));
         end
         step();
      end
      req  = keep_req;
      gnt  = 1'b0;
      data = h;
      par  = 4'b1010;
      step();
      for (int k = 0; k < pb; k++) begin
         data  = pl[k];
         par   = par_of(pl[k], odd) ^ flip[4*k +: 4];
         gnt   = (k == ovl_beat);
         reset = (k == rst_beat);
         if (k == den_beat) en_a = 1'b0;
         step();
         if (k == rst_beat) begin
            reset = 1'b0;
            exp_pkt = '{0, 0};
            exp_err = '{0, 0};
            break;
         end
      end
      gnt  = 1'b0;
      data = '0;
      par  = '0;
   endtask

   // Scoreboard monitors: pop and compare whenever an instance presents a packet.
   always @(negedge clk) begin
      if (vld_a === 1'b1) begin
         if (q_a.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL a_unexpected_pkt: pkt_vld at cycle %0d, required none", cyc);
         end else begin
            e_a = q_a.pop_front();
            check("a_pkt_hdr", hdr_a, e_a.hdr);
            check("a_pkt_pld", pld_a, e_a.pld);
            check("a_pkt_par_err", perr_a, e_a.perr);
            check("a_pkt_cnt", pcnt_a, e_a.pcnt);
            check("a_err_cnt", ecnt_a, e_a.ecnt);
            check("a_pkt_cycle", cyc, e_a.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (vld_b === 1'b1) begin
         if (q_b.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL b_unexpected_pkt: pkt_vld at cycle %0d, required none", cyc);
         end else begin
            e_b = q_b.pop_front();
            check("b_pkt_hdr", hdr_b, e_b.hdr);
            check("b_pkt_pld", pld_b, e_b.pld);
            check("b_pkt_par_err", perr_b, e_b.perr);
            check("b_pkt_cnt", pcnt_b, e_b.pcnt);
            check("b_err_cnt", ecnt_b, e_b.ecnt);
            check("b_pkt_cycle", cyc, e_b.cyc);
         end
      end
   end

   initial begin
      step();
      en_a = 1'b1;
      do_reset();

      // Nominal even-parity transfer.
      xfer(0, 64'hA5A5_0001, 1, 2, 3, 4, 3, 0, 16'h0, -1, 0, -1, -1, 0);
      chk(0, "nominal", 4'b0000, 0, 1, 0);

      // Parity error: dparity[1] flipped on beat 2.
      do_reset();
      xfer(0, 64'hA5A5_0002, 1, 2, 3, 4, 3, 0, 16'h0200, -1, 0, -1, -1, 0);
      chk(0, "parity", 4'b0000, 1, 1, 0);

      // Protocol errors: spurious grant, overlapping grant, request drop.
      do_reset();
      gnt = 1'b1; step(); gnt = 1'b0;
      chk(0, "spur", 4'b1000, 1, 0, 0);
      exp_err[0] = 1;
      xfer(0, 64'h0000_BEEF, 64'h1234_5678, 64'h9ABC_DEF0, 64'h0F0F_F0F0, 64'hFFFF_0000,
           2, 0, 16'h0, 1, 1, -1, -1, 0);
      chk(0, "ovl", 4'b1100, 2, 1, 0);
      req = 1'b1; step(); step(); req = 1'b0; step();
      chk(0, "drop", 4'b1110, 3, 1, 0);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk(0, "clr", 4'b0000, 0, 1, 0);
      err_clr = 1'b1; gnt = 1'b1; step(); err_clr = 1'b0; gnt = 1'b0;
      chk(0, "clr_vs_event", 4'b1000, 1, 1, 0);
      en_a = 1'b0; gnt = 1'b1; step(); gnt = 1'b0; req = 1'b1; step();
      chk(0, "disabled", 4'b1000, 1, 1, 0);
      req = 1'b0; en_a = 1'b1;

      // Grant timeout with late grant still accepted.
      do_reset();
      xfer(0, 64'h7777_0008, 64'h11, 64'h22, 64'h33, 64'h44, 12, 0, 16'h0, -1, 1, -1, -1, 1);
      chk(0, "tmo_end", 4'b0001, 1, 1, 0);

      // Back-to-back with req held; then same-cycle req/gnt and mid-transfer disable.
      do_reset();
      xfer(0, 64'hB2B0_0001, 64'hA, 64'hB, 64'hC, 64'hD, 3, 1, 16'h0, -1, 0, -1, -1, 0);
      xfer(0, 64'hB2B0_0002, 64'h8000_0001, 64'h0001_8000, 64'hFFFF_FFFF, 64'h0,
           1, 0, 16'h0, -1, 0, -1, -1, 0);
      chk(0, "b2b", 4'b0000, 0, 2, 0);
      xfer(0, 64'hD15A_0003, 64'h5, 64'h6, 64'h7, 64'h8, 0, 1, 16'h0, -1, 0, -1, 1, 0);
      step();
      chk(0, "disable_mid", 4'b0000, 0, 3, 0);
      req = 1'b0; en_a = 1'b1;

      // Reset in payload beat 1, then a clean transfer.
      do_reset();
      xfer(0, 64'h1111_0001, 64'h1, 64'h2, 64'h3, 64'h4, 1, 0, 16'h0, -1, 0, -1, -1, 0);
      xfer(0, 64'h2222_0002, 64'h5, 64'h6, 64'h7, 64'h8, 1, 0, 16'h0, -1, 0, 1, -1, 0);
      chk_zero("reset_mid");
      xfer(0, 64'h3333_0003, 64'h9, 64'hA, 64'hB, 64'hC, 1, 0, 16'h0, -1, 0, -1, -1, 0);
      chk(0, "after_reset", 4'b0000, 0, 1, 0);

      // Counter saturation: 5 packets, 4 with parity errors, 2-bit counters.
      do_reset();
      for (int n = 0; n < 5; n++)
         xfer(0, 64'h5A70_0000 | 64'(n), 64'(n), 64'hF0, 64'h0F, 64'h3C,
              1, 0, (n == 0) ? 16'h0 : 16'h0001, -1, 0, -1, -1, 0);
      chk(0, "saturate", 4'b0000, 3, 3, 0);

      // 64-bit, 2-beat, odd-parity instance; the 32-bit one is disabled.
      en_a = 1'b0; en_b = 1'b1;
      do_reset();
      xfer(1, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0001, 64'hFFFF_0000_1234_8001,
           0, 0, 3, 1, 16'h0, -1, 0, -1, -1, 0);
      xfer(1, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0000, 64'h0101_0202_0303_0404,
           0, 0, 1, 0, 16'h0, -1, 0, -1, -1, 0);
      chk(1, "b_b2b", 4'b0000, 0, 2, 0);
      xfer(1, 64'hCAFE_0000_0000_0003, 64'h1, 64'h2, 0, 0, 2, 0, 16'h0080, -1, 0, -1, -1, 0);
      chk(1, "b_parity", 4'b0000, 1, 3, 0);
      chk(0, "a_frozen", 4'b0000, 0, 0, 0);

      step(); step();
      check("a_queue_empty", q_a.size(), 0);
      check("b_queue_empty", q_b.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
